// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Multi-cycle fetch/decode/execute controller for an 8-bit accumulator
//   datapath. It owns the PC, the instruction register, the carry and branch
//   flags, and a sticky memory-timeout error flag. It drives the ALU control
//   fields, sequences register-file writes, and runs the data-memory
//   req/ack handshake.
//
//   Instruction word: [8:5]=op, [4:3]=funct/imm, [2:0]=reg.
//
// Ports
//   Clk, Reset_n    clock (rising edge) / asynchronous active-low reset
//   start           begin execution at PC=0 (honoured in IDLE/HALT only)
//   inst_addr       instruction ROM address (= PC)
//   inst_data       ROM data, valid the cycle after inst_addr
//   alu_op/funct/imm/carry_in   ALU control driven from IR and carry flag
//   alu_carry_out, alu_branch   ALU carry and compare results
//   rf_addr, rf_rdata           RF address (= IR[2:0]) and R[reg] read data
//   rf_we, rf_wdst, rf_wsel     RF write strobe, destination and data select
//   mem_req, mem_we, mem_ack    data-memory handshake
//   busy, done, err             status: running, halted, memory timeout
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            start,
    output logic [PC_W-1:0] inst_addr,
    input  logic [8:0]      inst_data,
    output logic [3:0]      alu_op,
    output logic [1:0]      alu_funct,
    output logic [1:0]      alu_imm,
    output logic            alu_carry_in,
    input  logic            alu_carry_out,
    input  logic            alu_branch,
    output logic [2:0]      rf_addr,
    input  logic [7:0]      rf_rdata,
    output logic            rf_we,
    output logic            rf_wdst,
    output logic            rf_wsel,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b0110;
    localparam logic [3:0] OP_JUMP  = 4'b0111;
    localparam logic [3:0] OP_MOVR  = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            carry_q, carry_d;
    logic            branch_q, branch_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]      ir_op;
    logic [1:0]      ir_funct;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_target;

    assign ir_op    = ir_q[8:5];
    assign ir_funct = ir_q[4:3];
    assign pc_inc   = pc_q + 1'b1;   // wraps naturally at 2^PC_W-1

    // Jump target is R[reg], truncated or zero-extended to the PC width.
    generate
        if (PC_W <= 8) begin : g_tgt_trunc
            assign jump_target = rf_rdata[PC_W-1:0];
        end else begin : g_tgt_ext
            assign jump_target = {{(PC_W-8){1'b0}}, rf_rdata};
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            branch_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            branch_q <= branch_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        branch_d = branch_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rf_we    = 1'b0;
        rf_wdst  = 1'b0;
        rf_wsel  = 1'b0;
        mem_req  = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = inst_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                cnt_d   = '0;
                case (ir_op)
                    OP_LOAD, OP_STORE: begin
                        // PC advances only once the memory acknowledges.
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    4'b0010, 4'b0011, 4'b1100, 4'b1101, 4'b1110: begin
                        rf_we   = 1'b1;
                        rf_wdst = 1'b1;
                    end
                    4'b0100, 4'b0101: begin
                        rf_we = 1'b1;
                    end
                    OP_MOVR: begin
                        rf_we   = 1'b1;
                        rf_wdst = (ir_funct == 2'b00);
                    end
                    OP_CMP: begin
                        branch_d = (ir_funct != 2'b11) && alu_branch;
                    end
                    OP_JUMP: begin
                        if (branch_q) begin
                            pc_d = jump_target;
                        end
                        branch_d = 1'b0;
                    end
                    default: ;
                endcase
                if (ir_op inside {4'b0010, 4'b0011, 4'b0100, 4'b1100}) begin
                    carry_d = alu_carry_out;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                // An ack in the final allowed cycle still wins over timeout.
                if (mem_ack) begin
                    pc_d    = pc_inc;
                    state_d = (ir_op == OP_STORE) ? S_FETCH : S_WB;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wsel = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign inst_addr    = pc_q;
    assign alu_op       = ir_op;
    assign alu_funct    = ir_funct;
    assign alu_imm      = ir_funct;
    assign alu_carry_in = carry_q;
    assign rf_addr      = ir_q[2:0];
    assign mem_we       = mem_req && (ir_op == OP_STORE);
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done         = (state_q == S_HALT);
    assign err          = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Scoreboard bench. An instruction-level reference model walks each program
//   and pushes the observable events (RF write, memory request, halt) with
//   their expected cycle offsets into a queue; a monitor pops and compares
//   whenever the DUT presents one. ALU results, RF read data and memory
//   latency are per-address tables so the model can predict them.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int TO   = 16;
    localparam int MAXN = 40;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] inst_addr;
    logic [8:0] inst_data = '0;
    logic [3:0] alu_op;
    logic [1:0] alu_funct;
    logic [1:0] alu_imm;
    logic       alu_carry_in;
    logic       alu_carry_out;
    logic       alu_branch;
    logic [2:0] rf_addr;
    logic [7:0] rf_rdata;
    logic       rf_we, rf_wdst, rf_wsel;
    logic       mem_req, mem_we;
    logic       mem_ack = 1'b0;
    logic       busy, done, err;

    alu_sequencer #(.PC_W(8), .MEM_TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .inst_addr(inst_addr), .inst_data(inst_data),
        .alu_op(alu_op), .alu_funct(alu_funct), .alu_imm(alu_imm),
        .alu_carry_in(alu_carry_in), .alu_carry_out(alu_carry_out),
        .alu_branch(alu_branch), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_wdst(rf_wdst), .rf_wsel(rf_wsel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    logic [8:0] rom       [256];
    logic [7:0] rdata_tab [256];
    bit         cout_tab  [256];
    bit         br_tab    [256];
    int         dly_tab   [256];

    always @(posedge Clk) inst_data <= rom[inst_addr];
    assign rf_rdata      = rdata_tab[inst_addr];
    assign alu_carry_out = cout_tab[inst_addr];
    assign alu_branch    = br_tab[inst_addr];

    int cyc = 0;
    int base = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Memory responder: acks in MEM cycle dly_tab[pc]; stray acks elsewhere.
    int mcnt = 0;
    always @(negedge Clk) begin
        if (mem_req) begin
            mcnt    <= mcnt + 1;
            mem_ack <= ((mcnt + 1) == dly_tab[inst_addr]);
        end else begin
            mcnt    <= 0;
            mem_ack <= ($urandom_range(0, 7) == 0);
        end
    end

    // kind 0: RF write (a=addr b=wdst c=wsel), 1: mem request (a=addr b=we),
    // 2: halt (b=err); d is always the carry flag seen by the ALU.
    typedef struct {
        int kind; int t; int pc; int a; int b; int c; int d;
    } ev_t;
    typedef struct {
        string name; int act; int exp;
    } dchk_t;

    ev_t   exp_q[$];
    dchk_t dq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    m_carry  = 0;
    int    m_br     = 0;
    bit    m_halted = 0;

    function automatic ev_t mk_ev(input int kind, input int a, input int b,
                                  input int c);
        ev_t e;
        e.kind = kind; e.t = cyc - base; e.pc = int'(inst_addr);
        e.a = a; e.b = b; e.c = c; e.d = int'(alu_carry_in);
        return e;
    endfunction

    function automatic void check_ev(input ev_t a);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d t=%0d pc=%0h, required none",
                     a.kind, a.t, a.pc);
            return;
        end
        e = exp_q.pop_front();
        if (a.kind == e.kind && a.t == e.t && a.pc == e.pc && a.a == e.a &&
            a.b == e.b && a.c == e.c && a.d == e.d) begin
            n_pass++;
            $display("txn ok kind=%0d t=%0d pc=%0h a=%0d b=%0d c=%0d carry=%0d",
                     a.kind, a.t, a.pc, a.a, a.b, a.c, a.d);
        end else begin
            $display("FAIL event: got kind=%0d t=%0d pc=%0h a=%0d b=%0d c=%0d carry=%0d, required kind=%0d t=%0d pc=%0h a=%0d b=%0d c=%0d carry=%0d",
                     a.kind, a.t, a.pc, a.a, a.b, a.c, a.d,
                     e.kind, e.t, e.pc, e.a, e.b, e.c, e.d);
        end
    endfunction

    logic  mreq_prev = 1'b0;
    logic  done_prev = 1'b0;
    dchk_t dcur;
    always @(negedge Clk) begin
        if (rf_we)
            check_ev(mk_ev(0, int'(rf_addr), int'(rf_wdst), int'(rf_wsel)));
        if (mem_req && !mreq_prev)
            check_ev(mk_ev(1, int'(rf_addr), int'(mem_we), 0));
        if (done && !done_prev)
            check_ev(mk_ev(2, 0, int'(err), 0));
        mreq_prev <= mem_req;
        done_prev <= done;
        while (dq.size() > 0) begin
            dcur = dq.pop_front();
            n_checks++;
            if (dcur.act == dcur.exp) begin
                n_pass++;
                $display("txn ok %s = %0d", dcur.name, dcur.act);
            end else begin
                $display("FAIL %s: got %0d, required %0d", dcur.name, dcur.act, dcur.exp);
            end
        end
    end

    task automatic push_chk(input string name, input int act, input int exp);
        dchk_t c;
        c.name = name; c.act = act; c.exp = exp;
        dq.push_back(c);
    endtask

    task automatic push_ev(input int kind, input int t, input int pc, input int a,
                           input int b, input int c);
        ev_t e;
        e.kind = kind; e.t = t; e.pc = pc; e.a = a; e.b = b; e.c = c; e.d = m_carry;
        exp_q.push_back(e);
    endtask

    // Instruction-level model: t is the cycle offset of each FETCH from start.
    task automatic model_run();
        int pc = 0;
        int t = 0;
        int npc, op, f, r, d;
        m_halted = 0;
        for (int n = 0; n < MAXN; n++) begin
            op  = int'(rom[pc][8:5]);
            f   = int'(rom[pc][4:3]);
            r   = int'(rom[pc][2:0]);
            npc = (pc + 1) % 256;
            if (op == 0 || op == 1) begin
                d = dly_tab[pc];
                push_ev(1, t + 3, pc, r, int'(op == 1), 0);
                if (d > TO) begin
                    push_ev(2, t + 3 + TO, pc, 0, 1, 0);
                    m_halted = 1;
                    return;
                end
                if (op == 0) begin
                    push_ev(0, t + 3 + d, npc, r, 0, 1);
                    t += 4 + d;
                end else begin
                    t += 3 + d;
                end
                pc = npc;
            end else if (op == 15) begin
                push_ev(2, t + 3, pc, 0, 0, 0);
                m_halted = 1;
                return;
            end else begin
                if (op inside {2, 3, 12, 13, 14} || (op == 11 && f == 0))
                    push_ev(0, t + 2, pc, r, 1, 0);
                else if (op inside {4, 5, 11})
                    push_ev(0, t + 2, pc, r, 0, 0);
                if (op inside {2, 3, 4, 12}) m_carry = int'(cout_tab[pc]);
                if (op == 6) m_br = int'((f != 3) && br_tab[pc]);
                if (op == 7) begin
                    if (m_br != 0) npc = int'(rdata_tab[pc]);
                    m_br = 0;
                end
                pc = npc;
                t += 3;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        exp_q.delete();
        m_carry = 0;
        m_br    = 0;
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        base  = cyc + 1;
        @(negedge Clk);
        start = 1'b0;
        push_chk("start_clears_err", int'(err), 0);
        push_chk("start_busy", int'(busy), 1);
    endtask

    task automatic run_prog(input bit fresh);
        int waited = 0;
        if (fresh) do_reset();
        model_run();
        pulse_start();
        while (exp_q.size() != 0 && waited < 3000) begin
            @(posedge Clk);
            #1 waited++;
        end
        push_chk("scoreboard_drained", exp_q.size(), 0);
        if (!m_halted || exp_q.size() != 0) do_reset();
    endtask

    task automatic gen_blank();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 9'h1E0;
            rdata_tab[i] = 8'h00;
            cout_tab[i] = 1'b0;
            br_tab[i] = 1'b0;
            dly_tab[i] = 1;
        end
    endtask

    task automatic gen_random();
        for (int i = 0; i < 256; i++) begin
            rom[i]       = 9'($urandom_range(0, 511));
            rdata_tab[i] = 8'($urandom_range(0, 255));
            cout_tab[i]  = 1'($urandom_range(0, 1));
            br_tab[i]    = 1'($urandom_range(0, 1));
            dly_tab[i]   = int'($urandom_range(1, 18));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int waited;
        gen_blank();
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b1;
        @(negedge Clk);
        push_chk("reset_inst_addr", int'(inst_addr), 0);
        push_chk("reset_alu_fields", int'({alu_op, alu_funct, alu_imm}), 0);
        push_chk("reset_carry_in", int'(alu_carry_in), 0);
        push_chk("reset_busy", int'(busy), 0);
        push_chk("reset_done", int'(done), 0);
        push_chk("reset_err", int'(err), 0);
        push_chk("reset_mem_req", int'(mem_req), 0);
        push_chk("reset_rf_we", int'(rf_we), 0);

        // ALU write to R0 with carry, then halt.
        gen_blank();
        rom[0] = 9'b0100_00_001; cout_tab[0] = 1'b1;
        run_prog(1);
        // Halt from HALT again: carry flag must be retained.
        rom[0] = 9'b1000_00_000; rom[1] = 9'b1111_00_000;
        run_prog(0);

        // Compare sets branch, taken jump to 0x40, second jump not taken.
        gen_blank();
        rom[0] = 9'b0110_00_010; br_tab[0] = 1'b1;
        rom[1] = 9'b0111_00_011; rdata_tab[1] = 8'h40;
        rom[8'h40] = 9'b0111_00_000; rdata_tab[8'h40] = 8'h10;
        rom[8'h41] = 9'b0100_00_000;
        run_prog(1);

        // Load acked in its 5th memory cycle, then store acked at the limit.
        gen_blank();
        rom[0] = 9'b0000_00_001; dly_tab[0] = 5;
        rom[1] = 9'b0001_01_110; dly_tab[1] = TO;
        run_prog(1);

        // Store with no ack: timeout halt, twice (start from HALT clears err).
        gen_blank();
        rom[0] = 9'b0001_00_010; dly_tab[0] = 30;
        run_prog(1);
        run_prog(0);

        // PC wrap: jump to 0xFE, write, NOP at 0xFF, back to 0.
        gen_blank();
        rom[0] = 9'b0110_00_000; br_tab[0] = 1'b1;
        rom[1] = 9'b0111_00_001; rdata_tab[1] = 8'hFE;
        rom[8'hFE] = 9'b0100_00_011; cout_tab[8'hFE] = 1'b1;
        rom[8'hFF] = 9'b1000_00_000;
        run_prog(1);

        // Asynchronous reset in the middle of a load's memory wait.
        gen_blank();
        rom[0] = 9'b0000_00_100; dly_tab[0] = 12;
        do_reset();
        model_run();
        pulse_start();
        waited = 0;
        while (!mem_req && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        repeat (2) @(negedge Clk);
        push_chk("t1_mem_req_before", int'(mem_req), 1);
        #2 Reset_n = 1'b0;
        #1;
        push_chk("t1_mem_req_drop", int'(mem_req), 0);
        push_chk("t1_rf_we_drop", int'(rf_we), 0);
        push_chk("t1_busy_drop", int'(busy), 0);
        exp_q.delete();
        m_carry = 0;
        m_br = 0;
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        push_chk("t1_pc_after", int'(inst_addr), 0);
        push_chk("t1_idle_busy", int'(busy), 0);
        push_chk("t1_idle_done", int'(done), 0);

        // Randomized programs; halted runs sometimes restart straight from HALT.
        for (int k = 0; k < 30; k++) begin
            gen_random();
            run_prog((k % 2 == 0) || !m_halted);
        end

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
